// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory stage: FSM encoding, widths, WB select codes.
package core_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    // Memory-stage FSM: idle / waiting for the data-memory handshake.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Writeback source select codes carried on Sel_WBreg.
    localparam logic [REG_W-1:0] WB_SEL_ALU = 3'd0;
    localparam logic [REG_W-1:0] WB_SEL_MEM = 3'd1;
    localparam logic [REG_W-1:0] WB_SEL_PC  = 3'd2;
    localparam logic [REG_W-1:0] WB_SEL_IMM = 3'd3;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the memory stage and data memory.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_stage_ctrl_mw_latch.sv
// MEM/WB pipe register. The halt bit sits at the MSB so a bubble can be
// inserted generically: everything cleared, halt optionally forced.
module mw_latch #(
    parameter int SIZE = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            bubble_i,
    input  logic            bubble_halt_i,
    input  logic [SIZE-1:0] d_i,
    output logic [SIZE-1:0] q_o
);
    logic [SIZE-1:0] data_q;

    // Load every cycle: either the incoming fields or a (halting) bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       data_q <= '0;
        else if (bubble_i) data_q <= {bubble_halt_i, {(SIZE-1){1'b0}}};
        else               data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: consumes the EX/MEM latch, runs the req/ready handshake to
// data memory, stalls upstream while an access is outstanding, and drives
// the MEM/WB latch. Bad accesses and handshake timeouts raise a sticky err.
module mem_stage_ctrl
    import core_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15   // 1..15, REQ cycles before abort
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_XM,
    input  logic              halt_XM,
    input  logic              mem_read_XM,
    input  logic              mem_write_XM,
    input  logic [REG_W-1:0]  target_WBreg_XM,
    input  logic [REG_W-1:0]  Sel_WBreg_XM,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] Data2_XM,
    input  logic [DATA_W-1:0] nextPC_XM,
    mem_stage_ctrl_if.master  mem,
    output logic              stall_XM,
    output logic              reg_write_MW,
    output logic              halt_MW,
    output logic [REG_W-1:0]  target_WBreg_MW,
    output logic [REG_W-1:0]  Sel_WBreg_MW,
    output logic [DATA_W-1:0] mem_data_MW,
    output logic [DATA_W-1:0] alu_data_MW,
    output logic [DATA_W-1:0] nextPC_MW,
    output logic              err
);
    localparam int         MW_W     = 2 + 2*REG_W + 3*DATA_W;
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              access, bad_access;
    logic              bubble, bubble_halt;
    logic [DATA_W-1:0] mem_data_d;
    logic [MW_W-1:0]   mw_d, mw_q;

    assign access     = mem_read_XM | mem_write_XM;
    // Misaligned address or simultaneous read+write: never reaches memory.
    assign bad_access = access & (alu_data[0] | (mem_read_XM & mem_write_XM));

    // Bus is driven straight from state and the held XM fields.
    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_wr    = (state_q == REQ) & mem_write_XM;
    assign mem.mem_addr  = (state_q == REQ) ? alu_data : '0;
    assign mem.mem_wdata = (state_q == REQ) ? Data2_XM : '0;

    // State, timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: issue on a valid access, leave on ready or on timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (bad_access) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: stall while an access is pending, bubble MW until it resolves.
    always_comb begin
        stall_XM    = 1'b0;
        bubble      = 1'b0;
        bubble_halt = 1'b0;
        mem_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    bubble      = 1'b1;
                    bubble_halt = bad_access;
                    stall_XM    = ~bad_access;
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    mem_data_d = mem_write_XM ? '0 : mem.mem_rdata;
                end else if (cnt_q != CNT_LAST) begin
                    stall_XM = 1'b1;
                    bubble   = 1'b1;
                end else begin
                    bubble      = 1'b1;
                    bubble_halt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mw_d = {halt_XM, reg_write_XM, target_WBreg_XM, Sel_WBreg_XM,
                   mem_data_d, alu_data, nextPC_XM};

    mw_latch #(.SIZE(MW_W)) u_mw_latch (
        .clk_i         (clk),
        .rst_ni        (rst),
        .bubble_i      (bubble),
        .bubble_halt_i (bubble_halt),
        .d_i           (mw_d),
        .q_o           (mw_q)
    );

    assign {halt_MW, reg_write_MW, target_WBreg_MW, Sel_WBreg_MW,
            mem_data_MW, alu_data_MW, nextPC_MW} = mw_q;
    assign err = err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random instruction
// stream checked against a transaction-level model of the memory stage.
module tb_mem_stage_ctrl;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_XM, halt_XM, mem_read_XM, mem_write_XM;
    logic [2:0]  target_WBreg_XM, Sel_WBreg_XM;
    logic [15:0] alu_data, Data2_XM, nextPC_XM;
    logic        stall_XM, reg_write_MW, halt_MW, err;
    logic [2:0]  target_WBreg_MW, Sel_WBreg_MW;
    logic [15:0] mem_data_MW, alu_data_MW, nextPC_MW;

    mem_stage_ctrl_if #(.DATA_W(16)) bus();

    mem_stage_ctrl #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .reg_write_XM(reg_write_XM), .halt_XM(halt_XM),
        .mem_read_XM(mem_read_XM), .mem_write_XM(mem_write_XM),
        .target_WBreg_XM(target_WBreg_XM), .Sel_WBreg_XM(Sel_WBreg_XM),
        .alu_data(alu_data), .Data2_XM(Data2_XM), .nextPC_XM(nextPC_XM),
        .mem(bus),
        .stall_XM(stall_XM),
        .reg_write_MW(reg_write_MW), .halt_MW(halt_MW),
        .target_WBreg_MW(target_WBreg_MW), .Sel_WBreg_MW(Sel_WBreg_MW),
        .mem_data_MW(mem_data_MW), .alu_data_MW(alu_data_MW),
        .nextPC_MW(nextPC_MW), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rw, halt, rd, wr;
        bit [2:0]  tgt, sel;
        bit [15:0] addr, wdata, npc, rdata;
        int        lat;  // REQ cycles with ready low before ready is given
    } op_t;

    int vectors     = 0;
    int miscompares = 0;
    bit exp_err     = 0;

    // Observation of one instruction
    int          o_stall, o_req, o_wr;
    logic [55:0] o_mw;
    logic [15:0] o_addr, o_wdata;
    logic        o_bus_wr;
    bit          o_unstable, o_hung;

    // Expectation of one instruction
    int          e_stall, e_req, e_wr;
    logic [55:0] e_mw;

    function automatic logic [55:0] mw_now();
        return {halt_MW, reg_write_MW, target_WBreg_MW, Sel_WBreg_MW,
                mem_data_MW, alu_data_MW, nextPC_MW};
    endfunction

    // Transaction-level model: what one instruction does to the stage.
    task automatic model(input op_t op);
        bit access = op.rd | op.wr;
        bit bad    = access && (op.addr[0] || (op.rd && op.wr));
        if (!access) begin
            e_stall = 0; e_req = 0; e_wr = op.rw;
            e_mw = {op.halt, op.rw, op.tgt, op.sel, 16'h0, op.addr, op.npc};
        end else if (bad) begin
            e_stall = 0; e_req = 0; e_wr = 0;
            e_mw = {1'b1, 55'h0};
            exp_err = 1;
        end else if (op.lat < TIMEOUT) begin
            e_stall = op.lat + 1; e_req = op.lat + 1; e_wr = op.rw;
            e_mw = {op.halt, op.rw, op.tgt, op.sel,
                    (op.rd ? op.rdata : 16'h0), op.addr, op.npc};
        end else begin
            e_stall = TIMEOUT; e_req = TIMEOUT; e_wr = 0;
            e_mw = {1'b1, 55'h0};
            exp_err = 1;
        end
    endtask

    task automatic idle_xm();
        reg_write_XM = 0; halt_XM = 0; mem_read_XM = 0; mem_write_XM = 0;
        target_WBreg_XM = 0; Sel_WBreg_XM = 0;
        alu_data = 0; Data2_XM = 0; nextPC_XM = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
    endtask

    // Presents one instruction (starting at posedge+1), acts as the memory
    // and holds XM until stall drops. Ends at posedge+1 after the final edge.
    task automatic run_op(input op_t op);
        reg_write_XM = op.rw; halt_XM = op.halt;
        mem_read_XM = op.rd; mem_write_XM = op.wr;
        target_WBreg_XM = op.tgt; Sel_WBreg_XM = op.sel;
        alu_data = op.addr; Data2_XM = op.wdata; nextPC_XM = op.npc;
        bus.mem_rdata = op.rdata; bus.mem_ready = 0;
        o_stall = 0; o_req = 0; o_wr = 0; o_unstable = 0; o_hung = 1;
        o_addr = 0; o_wdata = 0; o_bus_wr = 0;
        for (int c = 0; c < 40; c++) begin
            logic st;
            #2;
            if (bus.mem_req) begin
                if (o_req == 0) begin
                    o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_bus_wr = bus.mem_wr;
                end else if (bus.mem_addr !== o_addr || bus.mem_wdata !== o_wdata ||
                             bus.mem_wr !== o_bus_wr) begin
                    o_unstable = 1;
                end
                bus.mem_ready = (o_req == op.lat);
                o_req++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));  // must be ignored
            end
            #1;
            st = stall_XM;
            @(posedge clk); #1;
            bus.mem_ready = 0;
            if (reg_write_MW === 1'b1) o_wr++;
            if (st === 1'b0) begin o_hung = 0; break; end
            o_stall++;
        end
        o_mw = mw_now();
        idle_xm();
    endtask

    task automatic test_reset();
        idle_xm();
        rst = 0;
        #12;
        vectors++;
        if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        vectors++;
        if (mw_now() !== 56'h0) begin miscompares++; $display("FAIL reset_mw: got %h want 0", mw_now()); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_pass();
        op_t op = '{rw:1, halt:0, rd:0, wr:0, tgt:3, sel:0, addr:16'h1234,
                    wdata:16'h5555, npc:16'h0102, rdata:16'h0, lat:0};
        run_op(op);
        vectors++;
        if (o_stall !== 0) begin miscompares++; $display("FAIL alu_stall: got %0d want 0", o_stall); end
        vectors++;
        if (o_mw !== {1'b0, 1'b1, 3'd3, 3'd0, 16'h0, 16'h1234, 16'h0102}) begin
            miscompares++; $display("FAIL alu_mw: got %h want 0b00000_1234_0102-style fields", o_mw);
        end
        vectors++;
        if (o_req !== 0) begin miscompares++; $display("FAIL alu_req: got %0d want 0", o_req); end
    endtask

    task automatic test_load_delay();
        op_t op = '{rw:1, halt:0, rd:1, wr:0, tgt:5, sel:1, addr:16'h0040,
                    wdata:16'h0, npc:16'h0200, rdata:16'hBEEF, lat:2};
        run_op(op);
        vectors++;
        if (o_req !== 3) begin miscompares++; $display("FAIL load_req: got %0d want 3", o_req); end
        vectors++;
        if (o_stall !== 3) begin miscompares++; $display("FAIL load_stall: got %0d want 3", o_stall); end
        vectors++;
        if (mem_data_MW !== 16'hBEEF) begin miscompares++; $display("FAIL load_data: got %h want beef", mem_data_MW); end
        vectors++;
        if (o_wr !== 1) begin miscompares++; $display("FAIL load_wr_hits: got %0d want 1", o_wr); end
        vectors++;
        if (o_addr !== 16'h0040 || o_bus_wr !== 1'b0 || o_unstable) begin
            miscompares++; $display("FAIL load_bus: got addr %h wr %b unstable %b want 0040 0 0", o_addr, o_bus_wr, o_unstable);
        end
    endtask

    task automatic test_store_immediate();
        op_t op = '{rw:0, halt:0, rd:0, wr:1, tgt:2, sel:0, addr:16'h0010,
                    wdata:16'h00A5, npc:16'h0300, rdata:16'hFFFF, lat:0};
        run_op(op);
        vectors++;
        if (o_req !== 1 || o_stall !== 1) begin
            miscompares++; $display("FAIL store_timing: got req %0d stall %0d want 1 1", o_req, o_stall);
        end
        vectors++;
        if (o_bus_wr !== 1'b1 || o_wdata !== 16'h00A5 || o_addr !== 16'h0010) begin
            miscompares++; $display("FAIL store_bus: got wr %b wdata %h addr %h want 1 00a5 0010", o_bus_wr, o_wdata, o_addr);
        end
        vectors++;
        if (o_wr !== 0 || mem_data_MW !== 16'h0) begin
            miscompares++; $display("FAIL store_mw: got wr_hits %0d data %h want 0 0000", o_wr, mem_data_MW);
        end
    endtask

    task automatic test_misaligned();
        op_t op = '{rw:1, halt:0, rd:1, wr:0, tgt:4, sel:1, addr:16'h0013,
                    wdata:16'h0, npc:16'h0400, rdata:16'h1111, lat:0};
        run_op(op);
        vectors++;
        if (o_req !== 0 || o_stall !== 0) begin
            miscompares++; $display("FAIL misal_req: got req %0d stall %0d want 0 0", o_req, o_stall);
        end
        vectors++;
        if (halt_MW !== 1'b1 || reg_write_MW !== 1'b0) begin
            miscompares++; $display("FAIL misal_mw: got halt %b rw %b want 1 0", halt_MW, reg_write_MW);
        end
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL misal_err: got %b want 1", err); end
        exp_err = 1;
    endtask

    task automatic test_timeout();
        op_t op = '{rw:1, halt:0, rd:1, wr:0, tgt:6, sel:1, addr:16'h0100,
                    wdata:16'h0, npc:16'h0500, rdata:16'h2222, lat:1000};
        run_op(op);
        vectors++;
        if (o_req !== TIMEOUT) begin miscompares++; $display("FAIL tmo_req: got %0d want %0d", o_req, TIMEOUT); end
        vectors++;
        if (o_hung || o_stall !== TIMEOUT) begin
            miscompares++; $display("FAIL tmo_stall: got %0d hung %b want %0d", o_stall, o_hung, TIMEOUT);
        end
        vectors++;
        if (halt_MW !== 1'b1 || reg_write_MW !== 1'b0 || err !== 1'b1) begin
            miscompares++; $display("FAIL tmo_mw: got halt %b rw %b err %b want 1 0 1", halt_MW, reg_write_MW, err);
        end
        vectors++;
        if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL tmo_idle: got req %b want 0", bus.mem_req); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            op_t op;
            int kind, r;
            op.rw = 1'($urandom_range(0, 1));
            op.halt = ($urandom_range(0, 9) == 0);
            op.tgt = 3'($urandom); op.sel = 3'($urandom);
            op.wdata = 16'($urandom); op.npc = 16'($urandom); op.rdata = 16'($urandom);
            op.addr = 16'($urandom);
            op.rd = 0; op.wr = 0;
            kind = $urandom_range(0, 9);
            if (kind >= 4 && kind <= 6) begin op.rd = 1; op.addr[0] = 0; end
            else if (kind >= 7 && kind <= 8) begin op.wr = 1; op.addr[0] = 0; end
            else if (kind == 9) begin
                op.rd = 1; op.wr = 1'($urandom_range(0, 1));
                if (!op.wr) op.addr[0] = 1;
            end
            r = $urandom_range(0, 19);
            op.lat = (r < 14) ? r % 5 : (r == 14) ? 13 : (r == 15) ? 14 : 15 + r;
            model(op);
            run_op(op);
            vectors++;
            if (o_hung || o_stall !== e_stall) begin
                miscompares++; $display("FAIL rnd%0d_stall: got %0d want %0d", n, o_stall, e_stall);
            end
            vectors++;
            if (o_req !== e_req) begin miscompares++; $display("FAIL rnd%0d_req: got %0d want %0d", n, o_req, e_req); end
            vectors++;
            if (o_mw !== e_mw) begin miscompares++; $display("FAIL rnd%0d_mw: got %h want %h", n, o_mw, e_mw); end
            vectors++;
            if (o_wr !== e_wr) begin miscompares++; $display("FAIL rnd%0d_wrhits: got %0d want %0d", n, o_wr, e_wr); end
            vectors++;
            if (err !== exp_err) begin miscompares++; $display("FAIL rnd%0d_err: got %b want %b", n, err, exp_err); end
            if (e_req > 0) begin
                vectors++;
                if (o_addr !== op.addr || o_wdata !== op.wdata || o_bus_wr !== op.wr || o_unstable) begin
                    miscompares++;
                    $display("FAIL rnd%0d_bus: got %h %h %b unstable %b want %h %h %b", n,
                             o_addr, o_wdata, o_bus_wr, o_unstable, op.addr, op.wdata, op.wr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_req();
        op_t op = '{rw:1, halt:0, rd:1, wr:0, tgt:1, sel:1, addr:16'h0080,
                    wdata:16'h0, npc:16'h0600, rdata:16'h3333, lat:0};
        reg_write_XM = 1; mem_read_XM = 1; target_WBreg_XM = 1; Sel_WBreg_XM = 1;
        alu_data = 16'h0080; nextPC_XM = 16'h0600; bus.mem_ready = 0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL mid_pre_req: got %b want 1", bus.mem_req); end
        rst = 0;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req: got %b want 0", bus.mem_req); end
        vectors++;
        if (mw_now() !== 56'h0 || err !== 1'b0) begin
            miscompares++; $display("FAIL mid_mw: got mw %h err %b want 0 0", mw_now(), err);
        end
        exp_err = 0;
        idle_xm();
        #3 rst = 1;
        @(posedge clk); #1;
        run_op(op);
        vectors++;
        if (o_req !== 1 || o_stall !== 1 || mem_data_MW !== 16'h3333) begin
            miscompares++; $display("FAIL mid_after: got req %0d stall %0d data %h want 1 1 3333", o_req, o_stall, mem_data_MW);
        end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load_delay();
        test_store_immediate();
        test_misaligned();
        test_timeout();
        test_random();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
